spi_cmd_sequencer: RTL and testbench
====================================

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 255: idle cycles allowed between progress events before abort; used only with the timeout feature.
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_cmd_valid  in  1  command request.
REQ-005 o_cmd_ready  out  1  command accepted when high together with i_cmd_valid.
REQ-006 i_cmd_rw  in  1  1 = register read, 0 = register write.
REQ-007 i_cmd_addr  in  7  slave register address.
REQ-008 i_cmd_wdata  in  8  write data; ignored for reads.
REQ-009 o_rsp_valid  out  1  one-cycle response pulse.
REQ-010 o_rsp_rdata  out  8  byte received in the data phase.
REQ-011 o_rsp_err  out  1  response aborted by timeout; valid with o_rsp_valid.
REQ-012 o_TX_count  out  2  bytes per CS frame to the SPI master state machine; constant 2.
REQ-013 o_TX_byte  out  8  byte to the SPI master.
REQ-014 o_TX_DV  out  1  one-cycle byte strobe to the SPI master.
REQ-015 i_TX_Ready  in  1  SPI master state-machine ready.
REQ-016 i_RX_DV  in  1  SPI master received-byte strobe.
REQ-017 i_RX_byte  in  8  SPI master received byte.

Function
REQ-018 The block SHALL frame each command as two bytes under one CS: byte0 = {i_cmd_rw, i_cmd_addr}, byte1 = i_cmd_wdata (write) or 8'h00 (read).
REQ-019 States SHALL be IDLE, SEND_B0, SEND_B1, WAIT_RX, RESP; undefined encodings return to IDLE.
REQ-020 o_cmd_ready SHALL be high exactly when state = IDLE; handshake latches rw/addr/wdata and moves to SEND_B0.
REQ-021 SEND_B0: on i_TX_Ready=1 and o_TX_DV=0, next cycle o_TX_DV=1, o_TX_byte=byte0, state SEND_B1.
REQ-022 SEND_B1: same rule with byte1, state WAIT_RX.
REQ-023 o_TX_DV SHALL be registered, high for exactly one cycle per byte, never on two consecutive cycles.
REQ-024 o_TX_byte SHALL hold its value until the next strobe.
REQ-025 An internal 2-bit RX counter SHALL clear on command accept and increment on i_RX_DV in SEND_B0, SEND_B1, WAIT_RX.
REQ-026 i_RX_DV in IDLE or RESP SHALL be ignored.
REQ-027 The second counted i_RX_DV SHALL capture i_RX_byte into o_rsp_rdata and move to RESP, from SEND_B1 or WAIT_RX; the first RX byte is discarded.
REQ-028 RESP SHALL last one cycle with o_rsp_valid=1, then IDLE; no backpressure on the response.
REQ-029 Minimum command-to-response latency SHALL be bounded only by the SPI master; sequencer overhead is 1 cycle per strobe plus 1 cycle RESP.
REQ-030 i_cmd_valid during RESP SHALL not be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-031 With i_rst high at a clock edge: state IDLE, o_TX_DV=0, o_TX_byte=8'h00, o_rsp_valid=0, o_rsp_rdata=8'h00, o_rsp_err=0, RX counter 0, timeout counter 0.
REQ-032 Reset mid-frame SHALL abandon the command without emitting a response; o_cmd_ready is 1 from the first cycle after reset release.

Configuration
REQ-033 Macro SPI_CMD_SEQ_TIMEOUT_EN defined: a counter runs in SEND_B0/SEND_B1/WAIT_RX, clears on entry and on every o_TX_DV or counted i_RX_DV, and upon reaching TIMEOUT_CLKS forces RESP with o_rsp_err=1, o_rsp_rdata=8'h00.
REQ-034 Macro undefined: no counter is built, o_rsp_err is constant 0, the sequencer waits indefinitely.

Verification
REQ-035 Write addr 7'h12 data 8'hA5 -> MOSI bytes 8'h12, 8'hA5; o_TX_count=2; one o_rsp_valid, o_rsp_err=0.
REQ-036 Read addr 7'h05, slave MISO 8'hFF then 8'h3C -> MOSI 8'h85, 8'h00; o_rsp_rdata=8'h3C.
REQ-037 Back-to-back commands with i_cmd_valid held high -> second accepted only after RESP, each frame under its own CS low period.
REQ-038 i_rst pulsed after first o_TX_DV -> no o_rsp_valid, all outputs at reset values, next read completes correctly.
REQ-039 SPI_CMD_SEQ_TIMEOUT_EN, TIMEOUT_CLKS=16, i_TX_Ready held 0 after command accept -> o_rsp_valid with o_rsp_err=1 exactly 17 cycles after accept.
REQ-040 Spurious i_RX_DV in IDLE followed by a read -> captured data equals the second in-frame RX byte.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns a register read/write command into a two-byte
// SPI frame (address/rw byte, then data byte) for a byte-level SPI master,
// and returns the byte received during the data phase as a one-cycle response.
// Optional abort-on-stall watchdog: define SPI_CMD_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module spi_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CLKS = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  // command side
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rw,
  input  logic [6:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  // response side
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  // SPI master byte interface
  output logic [1:0] o_TX_count,
  output logic [7:0] o_TX_byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_byte
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_B0 = 3'd1,
    SEND_B1 = 3'd2,
    WAIT_RX = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] byte0_q;
  logic [7:0] byte1_q;
  logic [7:0] tx_byte_q;
  logic       tx_dv_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_valid_q;
  logic [1:0] rx_cnt_q;

  logic in_frame;
  logic tx_fire;
  logic rx_count;
  logic rx_last;
  logic tmo_hit;

  // The frame states are the only place where the SPI master's strobes matter
  assign in_frame = (state_q == SEND_B0) || (state_q == SEND_B1) || (state_q == WAIT_RX);
  // A new byte goes out only when the master is ready and we did not just strobe
  assign tx_fire  = ((state_q == SEND_B0) || (state_q == SEND_B1)) && i_TX_Ready && !tx_dv_q;
  assign rx_count = in_frame && i_RX_DV;
  // Second received byte of the frame carries the register read data
  assign rx_last  = rx_count && (rx_cnt_q == 2'd1) &&
                    ((state_q == SEND_B1) || (state_q == WAIT_RX));

  // A zero timeout would abort every frame on its first idle cycle
  if (TIMEOUT_CLKS == 0) begin : g_bad_timeout
    $error("spi_cmd_sequencer: TIMEOUT_CLKS must be nonzero");
  end

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             rsp_err_q;

  // Fires only on a cycle with no progress once the idle budget is used up
  assign tmo_hit = in_frame && !tx_fire && !rx_count && (tmo_q >= TMO_W'(TIMEOUT_CLKS));

  // Idle-cycle counter: held at zero outside a frame, cleared by any progress
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q <= '0;
    end else if (!in_frame || tx_fire || rx_count) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Error flag is updated together with every response and held in between
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_err_q <= 1'b0;
    end else if (rx_last) begin
      rsp_err_q <= 1'b0;
    end else if (tmo_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign tmo_hit   = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  // Command sequencer: accept, send two bytes, collect the data byte, respond
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rx_cnt_q    <= 2'd0;
    end else begin
      tx_dv_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (rx_count) begin
        rx_cnt_q <= rx_cnt_q + 2'd1;
      end

      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            byte0_q  <= {i_cmd_rw, i_cmd_addr};
            byte1_q  <= i_cmd_rw ? 8'h00 : i_cmd_wdata;
            rx_cnt_q <= 2'd0;
            state_q  <= SEND_B0;
          end
        end

        SEND_B0, SEND_B1, WAIT_RX: begin
          if (rx_last) begin
            rsp_rdata_q <= i_RX_byte;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tmo_hit) begin
            rsp_rdata_q <= 8'h00;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tx_fire) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= (state_q == SEND_B0) ? byte0_q : byte1_q;
            state_q   <= (state_q == SEND_B0) ? SEND_B1 : WAIT_RX;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_TX_count  = 2'd2;
  assign o_TX_byte   = tx_byte_q;
  assign o_TX_DV     = tx_dv_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer with a small SPI-master model.
`timescale 1ns/1ps

module tb_spi_cmd_sequencer;

  localparam int unsigned TMO = 16;

  logic       i_clk       = 1'b0;
  logic       i_rst       = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       i_cmd_rw    = 1'b0;
  logic [6:0] i_cmd_addr  = 7'h00;
  logic [7:0] i_cmd_wdata = 8'h00;
  logic       i_TX_Ready  = 1'b1;
  logic       i_RX_DV     = 1'b0;
  logic [7:0] i_RX_byte   = 8'h00;
  logic       o_cmd_ready;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_err;
  logic [1:0] o_TX_count;
  logic [7:0] o_TX_byte;
  logic       o_TX_DV;

  spi_cmd_sequencer #(.TIMEOUT_CLKS(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_rw    (i_cmd_rw),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_wdata (i_cmd_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_TX_count  (o_TX_count),
    .o_TX_byte   (o_TX_byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Ready  (i_TX_Ready),
    .i_RX_DV     (i_RX_DV),
    .i_RX_byte   (i_RX_byte)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } rsp_t;

  rsp_t       exp_rsp_q[$];
  logic [7:0] exp_mosi_q[$];
  logic [7:0] miso_q[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          mon_en = 1'b0;
  bit          inflight = 1'b0;
  bit          stall = 1'b0;
  bit          spur_req = 1'b0;
  bit          force_en = 1'b0;
  logic [7:0]  force_m0 = 8'h00;
  logic [7:0]  force_m1 = 8'h00;
  int          cyc = 0;
  int          acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model + monitor: expectations are derived from the command at handshake
  initial begin : monitor
    bit         prev_dv;
    rsp_t       r;
    rsp_t       got;
    logic [7:0] m0;
    logic [7:0] m1;
    prev_dv = 1'b0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        exp_rsp_q.delete();
        exp_mosi_q.delete();
        miso_q.delete();
        inflight = 1'b0;
        prev_dv  = 1'b0;
        continue;
      end
      if (!mon_en) continue;

      chk("cmd_ready", 32'(o_cmd_ready), 32'(inflight == 1'b0));

      if (o_TX_DV) begin
        chk("tx_dv_back_to_back", 32'(prev_dv), 32'd0);
        chk("tx_count", 32'(o_TX_count), 32'd2);
        if (exp_mosi_q.size() == 0) fail_evt("unexpected_tx_strobe");
        else chk("mosi_byte", 32'(o_TX_byte), 32'(exp_mosi_q.pop_front()));
      end
      prev_dv = o_TX_DV;

      if (o_rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          fail_evt("unexpected_rsp_valid");
        end else begin
          got = exp_rsp_q.pop_front();
          chk("rsp_rdata", 32'(o_rsp_rdata), 32'(got.rdata));
          chk("rsp_err", 32'(o_rsp_err), 32'(got.err));
          if (got.tmo) chk("timeout_latency", 32'(cyc - acc_cyc), 32'd17);
        end
        inflight = 1'b0;
      end

      if (i_cmd_valid && o_cmd_ready) begin
        inflight = 1'b1;
        acc_cyc  = cyc + 1;
        if (stall) begin
          r.rdata = 8'h00; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
          exp_mosi_q.push_back({i_cmd_rw, i_cmd_addr});
          exp_mosi_q.push_back(i_cmd_rw ? 8'h00 : i_cmd_wdata);
          m0 = force_en ? force_m0 : 8'($urandom);
          m1 = force_en ? force_m1 : 8'($urandom);
          miso_q.push_back(m0);
          miso_q.push_back(m1);
          r.rdata = m1; r.err = 1'b0; r.tmo = 1'b0;
        end
        exp_rsp_q.push_back(r);
      end
    end
  end

  // SPI master model: after each byte strobe, returns a MISO byte a few cycles later
  initial begin : slave
    int rx_wait;
    int gap;
    rx_wait = -1;
    gap     = -1;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst) begin
        i_RX_DV    = 1'b0;
        rx_wait    = -1;
        gap        = -1;
        i_TX_Ready = !stall;
        continue;
      end
      i_RX_DV = 1'b0;
      if (gap >= 0) gap--;
      if (rx_wait == 0) begin
        i_RX_DV   = 1'b1;
        i_RX_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        rx_wait   = -1;
        gap       = int'($urandom_range(0, 2));
      end else if (rx_wait > 0) begin
        rx_wait--;
      end
      if (o_TX_DV) rx_wait = int'($urandom_range(0, 5));
      if (spur_req && !i_RX_DV && rx_wait < 0 && gap < 0 && o_cmd_ready) begin
        i_RX_DV   = 1'b1;
        i_RX_byte = 8'hEE;
        spur_req  = 1'b0;
      end
      i_TX_Ready = !stall && rx_wait < 0 && gap < 0;
    end
  end

  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wd, input bit keep);
    int n;
    i_cmd_rw    = rw;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    i_cmd_valid = 1'b1;
    n = 0;
    @(negedge i_clk);
    while (!o_cmd_ready && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 2000) fail_evt("accept_timeout");
    @(posedge i_clk);
    #1;
    if (!keep) i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight || exp_rsp_q.size() != 0) && n < 3000) begin
      @(posedge i_clk);
      n++;
    end
    if (n >= 3000) fail_evt("drain_timeout");
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_tx_dv", 32'(o_TX_DV), 32'd0);
    chk("rst_tx_byte", 32'(o_TX_byte), 32'h00);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'h00);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n;
    bit  keep;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values();
    @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    mon_en = 1'b1;

    // Directed write: expect MOSI 12, A5
    issue(1'b0, 7'h12, 8'hA5, 1'b0);
    drain();

    // Directed read: MISO FF then 3C, expect MOSI 85, 00 and rdata 3C
    force_en = 1'b1; force_m0 = 8'hFF; force_m1 = 8'h3C;
    issue(1'b1, 7'h05, 8'h77, 1'b0);
    drain();
    force_en = 1'b0;

    // Back-to-back with valid held high
    issue(1'b0, 7'h21, 8'h5A, 1'b1);
    issue(1'b1, 7'h33, 8'h00, 1'b1);
    issue(1'b0, 7'h7F, 8'hC3, 1'b0);
    drain();

    // Spurious RX strobe while idle, then a read
    spur_req = 1'b1;
    n = 0;
    while (spur_req && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (spur_req) fail_evt("spurious_not_sent");
    force_en = 1'b1; force_m0 = 8'h11; force_m1 = 8'h96;
    issue(1'b1, 7'h40, 8'h00, 1'b0);
    drain();
    force_en = 1'b0;

    // Reset after the first byte strobe abandons the frame
    issue(1'b1, 7'h0A, 8'h00, 1'b0);
    n = 0;
    @(negedge i_clk);
    while (!o_TX_DV && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) fail_evt("first_strobe_timeout");
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    issue(1'b1, 7'h0B, 8'h00, 1'b0);
    drain();

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
    // Master never ready: abort with error after the idle budget
    stall = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    issue(1'b1, 7'h55, 8'h00, 1'b0);
    drain();
    stall = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
`endif

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      keep = ($urandom_range(0, 3) == 0) && (k != 39);
      issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
      end
    end
    drain();

    repeat (5) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
